word_byte_serializer: RTL and testbench

//  Transmit side of the byte-lane register path: accepts one 32-bit word from the datapath and emits
//  it as 1, 2 or 4 bytes, MSB first, over a valid/ready byte interface. Byte order matches the

---
 rtl/word_byte_serializer_pkg.sv | 29 ++
 rtl/word_byte_serializer.sv | 101 ++++++++++
 tb/tb_word_byte_serializer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/word_byte_serializer_pkg.sv
// Shared types and constants for the word-to-byte serializer.
// Optional feature macro used by the top: SER_ABORT_EN (adds an Abort input).
package ser_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  // Encoded transfer size; 2'b11 is treated as a full word.
  typedef enum logic [1:0] {
    SZ_1B = 2'b00,
    SZ_2B = 2'b01,
    SZ_4B = 2'b10
  } size_e;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Number of bytes emitted for a given size code (11 falls through to 4).
  function automatic logic [2:0] size_to_count(input size_e sz);
    case (sz)
      SZ_1B:   size_to_count = 3'd1;
      SZ_2B:   size_to_count = 3'd2;
      default: size_to_count = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/word_byte_serializer.sv
// word_byte_serializer: loads one 32-bit word and emits 1, 2 or 4 bytes MSB
// first over a valid/ready byte interface. A byte is transferred on any cycle
// where ByteValid and ByteReady are both high; ByteValid never depends
// combinationally on ByteReady, and ByteOut/Remain hold while stalled.
// Optional macro: SER_ABORT_EN adds an Abort input that ends a sequence early.
module word_byte_serializer
  import ser_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [1:0]        Size,
  input  logic [WORD_W-1:0] I,
  output logic [BYTE_W-1:0] ByteOut,
  output logic              ByteValid,
  input  logic              ByteReady,
  output logic              Busy,
  output logic              Done,
  output logic [2:0]        Remain,
`ifdef SER_ABORT_EN
  input  logic              Abort,
`endif
  output state_e            DbgState
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [2:0]        remain_q, remain_d;
  logic              done_q, done_d;
  logic              xfer;
  size_e             size_sel;

  assign size_sel = size_e'(Size);
  assign xfer     = (state_q == SEND) && ByteReady;

  // State, shift register, byte counter and Done pulse registers.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      remain_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      remain_q <= remain_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic: load left-aligned payload on accept, shift out on transfer.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d  = SEND;
          remain_d = size_to_count(size_sel);
          case (size_sel)
            SZ_1B:   shreg_d = {I[7:0], 24'h000000};
            SZ_2B:   shreg_d = {I[15:0], 16'h0000};
            default: shreg_d = I;
          endcase
        end
      end
      SEND: begin
        if (xfer) begin
          // Lower bytes are zero after the left-aligned load, so the final
          // shift leaves the register cleared for the idle state.
          shreg_d  = shreg_q << BYTE_W;
          remain_d = remain_q - 3'd1;
          if (remain_q == 3'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef SER_ABORT_EN
    // Abort ends the sequence silently; a coincident transfer still counted downstream.
    if (Abort && (state_q == SEND)) begin
      state_d  = IDLE;
      shreg_d  = '0;
      remain_d = '0;
      done_d   = 1'b0;
    end
`endif
  end

  assign ByteOut   = shreg_q[WORD_W-1 -: BYTE_W];
  assign ByteValid = (state_q == SEND);
  assign Busy      = (state_q == SEND);
  assign Done      = done_q;
  assign Remain    = remain_q;
  assign DbgState  = state_q;

endmodule

// File: tb/tb_word_byte_serializer.sv
// Bench for word_byte_serializer: directed steps plus a few random words.
module tb_word_byte_serializer;
  import ser_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [1:0]  Size;
  logic [31:0] I;
  logic [7:0]  ByteOut;
  logic        ByteValid;
  logic        ByteReady;
  logic        Busy;
  logic        Done;
  logic [2:0]  Remain;
  state_e      DbgState;
`ifdef SER_ABORT_EN
  logic        Abort;
`endif

  word_byte_serializer dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .Size      (Size),
    .I         (I),
    .ByteOut   (ByteOut),
    .ByteValid (ByteValid),
    .ByteReady (ByteReady),
    .Busy      (Busy),
    .Done      (Done),
    .Remain    (Remain),
`ifdef SER_ABORT_EN
    .Abort     (Abort),
`endif
    .DbgState  (DbgState)
  );

  // Clock
  always #5 Clock = ~Clock;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          xfer_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] exp_w[$];
  logic        mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_tests++;
    n_fail++;
    $error("FAIL %s: observed=timeout/underflow expected=event", tag);
  endtask

  // Reference model: zero-extended payload and its bytes, MSB first.
  task automatic push_expected(input logic [1:0] sz, input logic [31:0] w);
    int n;
    logic [31:0] z;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    if (n == 1) z = {24'h0, w[7:0]};
    else if (n == 2) z = {16'h0, w[15:0]};
    else z = w;
    exp_w.push_back(z);
    for (int k = n - 1; k >= 0; k--) exp_q.push_back(z[8*k +: 8]);
  endtask

  // Scoreboard / protocol monitor, sampled on the falling edge.
  logic        last_pend = 1'b0;
  logic        stall_pend = 1'b0;
  logic [7:0]  stall_byte = '0;
  logic [2:0]  stall_rem = '0;
  logic [31:0] acc = '0;
  logic        abort_now;

  always @(negedge Clock) begin
    if (mon_en) begin
`ifdef SER_ABORT_EN
      abort_now = Abort;
`else
      abort_now = 1'b0;
`endif
      check("done_pulse", Done, last_pend);
      if (stall_pend) begin
        check("stall_byte_hold", ByteOut, stall_byte);
        check("stall_remain_hold", Remain, stall_rem);
      end
      check("valid_eq_busy", ByteValid, Busy);
      check("remain_zero_iff_idle", Remain == 3'd0, !Busy);
      if (!Busy) check("idle_byte_zero", ByteOut, 0);
      if (Done) begin
        if (exp_w.size() == 0) fail_now("word_underflow");
        else check("reassembled_word", acc, exp_w.pop_front());
        acc = '0;
      end else if (!ByteValid) begin
        acc = '0;
      end
      last_pend  = Reset && ByteValid && ByteReady && (Remain == 3'd1) && !abort_now;
      stall_pend = Reset && ByteValid && !ByteReady && !abort_now;
      stall_byte = ByteOut;
      stall_rem  = Remain;
      if (Reset && ByteValid && ByteReady) begin
        xfer_cnt++;
        if (exp_q.size() == 0) fail_now("byte_underflow");
        else begin
          check("remain_count", Remain, exp_q.size());
          check("byte_out", ByteOut, exp_q.pop_front());
        end
        acc = {acc[23:0], ByteOut};
      end
    end
  end

  // Driver: raise Start now (caller is between edges), release after one edge.
  task automatic start_now(input logic [1:0] sz, input logic [31:0] w);
    check("accept_idle", Busy, 0);
    Start = 1'b1;
    Size  = sz;
    I     = w;
    push_expected(sz, w);
    @(posedge Clock); #1;
    Start = 1'b0;
    I     = $urandom;
  endtask

  // Runs until Done is seen at a falling edge; returns cycles since accept.
  task automatic wait_done(input int max_c, input bit rnd, output int cycles);
    cycles = 0;
    forever begin
      if (rnd) ByteReady = 1'($urandom_range(0, 1));
      @(negedge Clock);
      cycles++;
      if (cycles == 1) check("first_valid", ByteValid, 1);
      if (Done) break;
      if (cycles >= max_c) begin
        fail_now("done_timeout");
        break;
      end
      @(posedge Clock); #1;
    end
    ByteReady = 1'b1;
  endtask

  task automatic send_word(input logic [1:0] sz, input logic [31:0] w, input bit rnd,
                           input int exp_lat);
    int c;
    @(posedge Clock); #1;
    start_now(sz, w);
    wait_done(60, rnd, c);
    if (exp_lat != 0) check("done_latency", c, exp_lat);
  endtask

  task automatic wait_xfers(input int base, input int n);
    int g;
    g = 0;
    while ((xfer_cnt - base) < n && g < 20) begin
      @(posedge Clock); #1;
      g++;
    end
    if (g >= 20) fail_now("xfer_wait_timeout");
  endtask

  initial begin
    int c;
    int base;
    logic [6:0] pat;

    // Reset
    Reset = 1'b0; Start = 1'b0; Size = 2'b00; I = '0; ByteReady = 1'b1;
`ifdef SER_ABORT_EN
    Abort = 1'b0;
`endif
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check("rst_byte", ByteOut, 0);
    check("rst_valid", ByteValid, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_remain", Remain, 0);
    check("rst_state", DbgState, IDLE);
    @(posedge Clock); #1;
    Reset  = 1'b1;
    mon_en = 1'b1;

    // Full word, always ready
    send_word(2'b10, 32'hDEADBEEF, 1'b0, 5);
    check("busy_after_done", Busy, 0);

    // Short sizes and the 11 code
    send_word(2'b00, 32'h123456AB, 1'b0, 2);
    send_word(2'b01, 32'hFFFF8001, 1'b0, 3);
    send_word(2'b11, 32'hCAFEF00D, 1'b0, 5);

    // Backpressure pattern 1,0,0,1,0,1,1
    @(posedge Clock); #1;
    start_now(2'b10, 32'h01020304);
    base = xfer_cnt;
    pat = 7'b1101001;
    for (int k = 0; k < 7; k++) begin
      ByteReady = pat[k];
      @(posedge Clock); #1;
    end
    ByteReady = 1'b1;
    check("stall_xfer_count", xfer_cnt - base, 4);
    @(negedge Clock);
    check("stall_done", Done, 1);

    // Start while busy is ignored; Start in the Done cycle is accepted
    @(posedge Clock); #1;
    start_now(2'b10, 32'hA1B2C3D4);
    ByteReady = 1'b0;
    @(posedge Clock); #1;
    Start = 1'b1; Size = 2'b00; I = 32'h55667788;
    @(posedge Clock); #1;
    Start = 1'b0; ByteReady = 1'b1;
    wait_done(60, 1'b0, c);
    start_now(2'b01, 32'h0000BEEF);
    wait_done(60, 1'b0, c);
    check("b2b_latency", c, 3);

    // Reset after 2 of 4 bytes
    @(posedge Clock); #1;
    start_now(2'b10, 32'h89ABCDEF);
    base = xfer_cnt - 0;
    wait_xfers(base, 2);
    Reset = 1'b0;
    exp_q.delete();
    exp_w.delete();
    @(posedge Clock); #1;
    @(negedge Clock);
    check("midrst_byte", ByteOut, 0);
    check("midrst_valid", ByteValid, 0);
    check("midrst_busy", Busy, 0);
    check("midrst_done", Done, 0);
    check("midrst_remain", Remain, 0);
    check("midrst_xfers", xfer_cnt - base, 2);
    @(posedge Clock); #1;
    Reset = 1'b1;
    send_word(2'b10, 32'h13579BDF, 1'b0, 5);

`ifdef SER_ABORT_EN
    // Abort after byte 1 while stalled
    @(posedge Clock); #1;
    start_now(2'b10, 32'h11223344);
    base = xfer_cnt;
    wait_xfers(base, 1);
    Abort = 1'b1; ByteReady = 1'b0;
    exp_q.delete(); exp_w.delete();
    @(posedge Clock); #1;
    Abort = 1'b0; ByteReady = 1'b1;
    @(negedge Clock);
    check("abort_valid", ByteValid, 0);
    check("abort_done", Done, 0);
    check("abort_remain", Remain, 0);
    // Abort coincident with the second transfer
    @(posedge Clock); #1;
    start_now(2'b10, 32'h55AA33CC);
    base = xfer_cnt;
    wait_xfers(base, 1);
    Abort = 1'b1;
    @(posedge Clock); #1;
    Abort = 1'b0;
    exp_q.delete(); exp_w.delete();
    check("abort_xfer_count", xfer_cnt - base, 2);
    @(negedge Clock);
    check("abort2_valid", ByteValid, 0);
    check("abort2_done", Done, 0);
`endif

    // Random sizes, data and backpressure
    for (int n = 0; n < 8; n++) begin
      send_word(2'($urandom_range(0, 3)), $urandom, 1'b1, 0);
    end

    @(negedge Clock);
    check("queue_drained", exp_q.size(), 0);
    check("words_drained", exp_w.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
